// File: rtl/ibex_pkg.sv
// Shared encodings for the instruction fetch path: compressed-instruction
// detection and the halfword offset of the current fetch address.
package ibex_pkg;

  localparam logic [1:0] OPCODE_UNCOMPRESSED = 2'b11;

  typedef enum logic {
    HW_ALIGNED   = 1'b0,
    HW_UNALIGNED = 1'b1
  } hw_offset_e;

  function automatic logic is_compressed(input logic [1:0] low_bits);
    return low_bits != OPCODE_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/ibex_fetch_align.sv
// Combinational halfword aligner: builds one instruction from the two oldest
// available fetch words, given whether the current address is word aligned.
module ibex_fetch_align
  import ibex_pkg::*;
(
  input  hw_offset_e  offset,
  input  logic        valid0,
  input  logic [31:0] word0,
  input  logic        err0,
  input  logic        valid1,
  input  logic [31:0] word1,
  input  logic        err1,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        err_plus2,
  output logic        compressed
);

  // An unaligned uncompressed instruction straddles two words and must wait
  // for the second one; a fault on word0 always forces the two-word path.
  always_comb begin
    valid      = valid0;
    rdata      = word0;
    err        = err0;
    err_plus2  = 1'b0;
    compressed = is_compressed(word0[1:0]) & ~err0;
    if (offset == HW_UNALIGNED) begin
      compressed = is_compressed(word0[17:16]) & ~err0;
      rdata      = {word1[15:0], word0[31:16]};
      valid      = valid0 & (compressed | valid1);
      err        = err0 | (err1 & ~compressed);
      err_plus2  = err1 & ~err0 & ~compressed;
    end
  end

endmodule

// File: rtl/ibex_fetch_queue.sv
// Instruction fetch queue: in-order word FIFO with zero-latency bypass,
// halfword alignment, request flow control and flush/discard tracking.
module ibex_fetch_queue
  import ibex_pkg::*;
#(
  parameter  int NUM_REQS    = 2,
  parameter  int EXTRA_DEPTH = 1,
  parameter  int ALMOST_FULL = NUM_REQS + EXTRA_DEPTH - 1,
  localparam int DEPTH       = NUM_REQS + EXTRA_DEPTH,
  localparam int LW          = $clog2(DEPTH + 1),
  localparam int CW          = $clog2(NUM_REQS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic [31:0]   clear_addr_i,
  input  logic          req_issued_i,
  output logic          req_allow_o,
  input  logic          in_valid_i,
  input  logic [31:0]   in_rdata_i,
  input  logic          in_err_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   out_addr_o,
  output logic [31:0]   out_rdata_o,
  output logic          out_err_o,
  output logic          out_err_plus2_o,
  output logic          out_is_compressed_o,
  output logic [LW-1:0] level_o,
  output logic          almost_full_o,
  output logic [CW-1:0] outstanding_o,
  output logic [CW-1:0] discard_o
);

  logic [31:0]   rdata_q [DEPTH];
  logic          err_q   [DEPTH];
  logic [LW-1:0] level_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] discard_q;
  logic [31:0]   addr_q;

  logic          in_accept;
  logic          in_drop;
  logic          have0;
  logic          have1;
  logic          valid0;
  logic          valid1;
  logic [31:0]   word0;
  logic [31:0]   word1;
  logic          err0;
  logic          err1;
  hw_offset_e    offset;
  logic          align_valid;
  logic          compressed;
  logic          fire;
  logic          pop;
  logic          pop_stored;
  logic          store;
  logic [LW-1:0] wr_idx;
  logic [CW-1:0] inflight;

  assign in_accept = in_valid_i & ~clear_i & (discard_q == '0);
  assign in_drop   = in_valid_i & (discard_q != '0);
  assign inflight  = outstanding_q + discard_q;

  // Missing stored words are filled from the incoming response (bypass).
  assign have0  = level_q != '0;
  assign have1  = level_q > LW'(1);
  assign valid0 = have0 | in_accept;
  assign valid1 = have1 | (have0 & in_accept);
  assign word0  = have0 ? rdata_q[0] : in_rdata_i;
  assign err0   = have0 ? err_q[0]   : in_err_i;
  assign word1  = have1 ? rdata_q[1] : in_rdata_i;
  assign err1   = have1 ? err_q[1]   : in_err_i;
  assign offset = hw_offset_e'(addr_q[1]);

  ibex_fetch_align u_align (
    .offset     (offset),
    .valid0     (valid0),
    .word0      (word0),
    .err0       (err0),
    .valid1     (valid1),
    .word1      (word1),
    .err1       (err1),
    .valid      (align_valid),
    .rdata      (out_rdata_o),
    .err        (out_err_o),
    .err_plus2  (out_err_plus2_o),
    .compressed (compressed)
  );

  assign out_valid_o         = align_valid & ~clear_i;
  assign out_is_compressed_o = compressed;
  assign out_addr_o          = addr_q;

  // An aligned compressed instruction leaves its upper half in word0.
  assign fire       = out_valid_o & out_ready_i;
  assign pop        = fire & ~((offset == HW_ALIGNED) & compressed);
  assign pop_stored = pop & have0;
  assign store      = in_accept & ~(~have0 & pop);
  assign wr_idx     = level_q - LW'(pop_stored);

  always_ff @(posedge clk_i) begin
    if (pop_stored) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        rdata_q[i] <= rdata_q[i+1];
        err_q[i]   <= err_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (store && wr_idx == LW'(i)) begin
        rdata_q[i] <= in_rdata_i;
        err_q[i]   <= in_err_i;
      end
    end
  end

  // On a flush every request still in flight, minus any response arriving
  // now, becomes stale; a request issued in the flush cycle is already live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      addr_q        <= '0;
    end else if (clear_i) begin
      level_q       <= '0;
      outstanding_q <= CW'(req_issued_i);
      discard_q     <= inflight - CW'(in_valid_i);
      addr_q        <= {clear_addr_i[31:1], 1'b0};
    end else begin
      level_q       <= level_q + LW'(store) - LW'(pop_stored);
      outstanding_q <= outstanding_q + CW'(req_issued_i) - CW'(in_accept);
      discard_q     <= discard_q - CW'(in_drop);
      if (fire) begin
        addr_q <= addr_q + (compressed ? 32'd2 : 32'd4);
      end
    end
  end

  assign req_allow_o   = (int'(inflight) < NUM_REQS) &&
                         (int'(inflight) + int'(level_q) < DEPTH);
  assign almost_full_o = int'(level_q) >= ALMOST_FULL;
  assign level_o       = level_q;
  assign outstanding_o = outstanding_q;
  assign discard_o     = discard_q;

  a_no_unexpected_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_valid_i && outstanding_q == '0 && discard_q == '0));

endmodule

// File: tb/tb_ibex_fetch_queue.sv
// Directed bench for ibex_fetch_queue: expected instructions go into a
// scoreboard queue and a monitor compares them at each output handshake.
module tb_ibex_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [31:0] clear_addr_i;
  logic        req_issued_i;
  logic        req_allow_o;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_rdata_o;
  logic        out_err_o;
  logic        out_err_plus2_o;
  logic        out_is_compressed_o;
  logic [1:0]  level_o;
  logic        almost_full_o;
  logic [1:0]  outstanding_o;
  logic [1:0]  discard_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
    logic        plus2;
    logic        comp;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;

  always #5 clk_i = ~clk_i;

  ibex_fetch_queue dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .clear_i             (clear_i),
    .clear_addr_i        (clear_addr_i),
    .req_issued_i        (req_issued_i),
    .req_allow_o         (req_allow_o),
    .in_valid_i          (in_valid_i),
    .in_rdata_i          (in_rdata_i),
    .in_err_i            (in_err_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_addr_o          (out_addr_o),
    .out_rdata_o         (out_rdata_o),
    .out_err_o           (out_err_o),
    .out_err_plus2_o     (out_err_plus2_o),
    .out_is_compressed_o (out_is_compressed_o),
    .level_o             (level_o),
    .almost_full_o       (almost_full_o),
    .outstanding_o       (outstanding_o),
    .discard_o           (discard_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // One clock cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic clr, input logic [31:0] caddr,
                               input logic iss, input logic vld,
                               input logic [31:0] data, input logic err,
                               input logic rdy);
    @(posedge clk_i);
    #1;
    clear_i      = clr;
    clear_addr_i = caddr;
    req_issued_i = iss;
    in_valid_i   = vld;
    in_rdata_i   = data;
    in_err_i     = err;
    out_ready_i  = rdy;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic issue(input logic rdy);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic respond(input logic [31:0] data, input logic err, input logic rdy);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, data, err, rdy);
  endtask

  task automatic clear_to(input logic [31:0] addr, input logic iss, input logic rdy);
    applyStimulus(1'b1, addr, iss, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic expect_out(input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] mask, input logic err,
                            input logic plus2, input logic comp);
    exp_t e;
    e.addr = addr; e.rdata = rdata; e.mask = mask;
    e.err = err; e.plus2 = plus2; e.comp = comp;
    sb.push_back(e);
  endtask

  task automatic at_negedge();
    @(negedge clk_i);
  endtask

  // Monitor: every accepted instruction must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_addr", out_addr_o, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_addr", out_addr_o, e.addr);
        checkOutput("out_rdata", out_rdata_o & e.mask, e.rdata & e.mask);
        checkOutput("out_err", 32'(out_err_o), 32'(e.err));
        checkOutput("out_err_plus2", 32'(out_err_plus2_o), 32'(e.plus2));
        checkOutput("out_is_compressed", 32'(out_is_compressed_o), 32'(e.comp));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; clear_addr_i = 32'h0; req_issued_i = 1'b0;
    in_valid_i = 1'b0; in_rdata_i = 32'h0; in_err_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    at_negedge();
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("rst_discard", 32'(discard_o), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_req_allow", 32'(req_allow_o), 32'd1);
    checkOutput("rst_almost_full", 32'(almost_full_o), 32'd0);
    checkOutput("rst_addr", out_addr_o, 32'h0);
    @(posedge clk_i); #1; rst_i = 1'b0;

    $display("[TB] aligned compressed pair then uncompressed word");
    clear_to(32'h100, 1'b0, 1'b1);
    at_negedge(); checkOutput("clear_cycle_valid", 32'(out_valid_o), 32'd0);
    issue(1'b1); issue(1'b1);
    respond(32'h0001_0001, 1'b0, 1'b1);
    expect_out(32'h100, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    respond(32'h0000_0013, 1'b0, 1'b1);
    expect_out(32'h102, 32'h0013_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    expect_out(32'h104, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    at_negedge();
    checkOutput("s1_level", 32'(level_o), 32'd0);
    checkOutput("s1_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("s1_addr", out_addr_o, 32'h108);

    $display("[TB] unaligned uncompressed waits for second word");
    clear_to(32'h102, 1'b0, 1'b1);
    issue(1'b1); issue(1'b1);
    respond(32'h0003_4501, 1'b0, 1'b1);
    at_negedge(); checkOutput("s2_wait_valid", 32'(out_valid_o), 32'd0);
    respond(32'h1234_5678, 1'b0, 1'b1);
    expect_out(32'h102, 32'h5678_0003, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    expect_out(32'h106, 32'h0000_1234, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    at_negedge();
    checkOutput("s2_addr", out_addr_o, 32'h108);
    checkOutput("s2_level", 32'(level_o), 32'd0);

    $display("[TB] flush with requests in flight");
    issue(1'b1); issue(1'b1);
    at_negedge(); checkOutput("s3_outstanding_pre", 32'(outstanding_o), 32'd1);
    clear_to(32'h200, 1'b1, 1'b1);
    at_negedge(); checkOutput("s3_clear_valid", 32'(out_valid_o), 32'd0);
    respond(32'hDEAD_BEEF, 1'b0, 1'b1);
    at_negedge();
    checkOutput("s3_discard", 32'(discard_o), 32'd2);
    checkOutput("s3_outstanding", 32'(outstanding_o), 32'd1);
    checkOutput("s3_drop1_valid", 32'(out_valid_o), 32'd0);
    respond(32'hCAFE_F00D, 1'b0, 1'b1);
    at_negedge();
    checkOutput("s3_discard_dec", 32'(discard_o), 32'd1);
    checkOutput("s3_drop2_valid", 32'(out_valid_o), 32'd0);
    respond(32'h0000_0013, 1'b0, 1'b1);
    expect_out(32'h200, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    at_negedge();
    checkOutput("s3_discard_end", 32'(discard_o), 32'd0);
    checkOutput("s3_outstanding_end", 32'(outstanding_o), 32'd0);
    checkOutput("s3_addr", out_addr_o, 32'h204);

    $display("[TB] unaligned error on second word");
    clear_to(32'h302, 1'b0, 1'b1);
    issue(1'b1); issue(1'b1);
    respond(32'h0003_0000, 1'b0, 1'b1);
    respond(32'h0003_5555, 1'b1, 1'b1);
    expect_out(32'h302, 32'h5555_0003, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    at_negedge();
    checkOutput("s4a_valid", 32'(out_valid_o), 32'd0);
    checkOutput("s4a_addr", out_addr_o, 32'h306);

    $display("[TB] unaligned error on first word");
    clear_to(32'h402, 1'b0, 1'b1);
    issue(1'b1); issue(1'b1);
    respond(32'h0003_0000, 1'b1, 1'b1);
    at_negedge(); checkOutput("s4b_wait_valid", 32'(out_valid_o), 32'd0);
    respond(32'h0003_1111, 1'b0, 1'b1);
    expect_out(32'h402, 32'h1111_0003, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    at_negedge();
    checkOutput("s4b_valid", 32'(out_valid_o), 32'd0);
    checkOutput("s4b_addr", out_addr_o, 32'h406);

    $display("[TB] backpressure and flow control");
    clear_to(32'h500, 1'b0, 1'b0);
    issue(1'b0); issue(1'b0);
    at_negedge(); checkOutput("s5_allow_out2", 32'(req_allow_o), 32'd1);
    respond(32'h0000_0013, 1'b0, 1'b0);
    at_negedge(); checkOutput("s5_allow_full_reqs", 32'(req_allow_o), 32'd0);
    issue(1'b0);
    at_negedge();
    checkOutput("s5_allow_level1", 32'(req_allow_o), 32'd1);
    checkOutput("s5_af_level1", 32'(almost_full_o), 32'd0);
    respond(32'h0010_0093, 1'b0, 1'b0);
    at_negedge(); checkOutput("s5_allow_out2b", 32'(req_allow_o), 32'd0);
    idle(1'b0);
    at_negedge();
    checkOutput("s5_level2", 32'(level_o), 32'd2);
    checkOutput("s5_af_level2", 32'(almost_full_o), 32'd1);
    checkOutput("s5_allow_sum3", 32'(req_allow_o), 32'd0);
    respond(32'h0020_0113, 1'b0, 1'b0);
    idle(1'b0);
    at_negedge();
    checkOutput("s5_level3", 32'(level_o), 32'd3);
    checkOutput("s5_allow_level3", 32'(req_allow_o), 32'd0);
    checkOutput("s5_valid_held", 32'(out_valid_o), 32'd1);
    expect_out(32'h500, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    expect_out(32'h504, 32'h0010_0093, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    expect_out(32'h508, 32'h0020_0113, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b1);
    at_negedge();
    checkOutput("s5_level_drained", 32'(level_o), 32'd0);
    checkOutput("s5_allow_drained", 32'(req_allow_o), 32'd1);
    checkOutput("s5_addr", out_addr_o, 32'h50C);

    $display("[TB] reset mid-stream");
    clear_to(32'h600, 1'b0, 1'b0);
    issue(1'b0); issue(1'b0);
    respond(32'h0000_0013, 1'b0, 1'b0);
    respond(32'h0000_0013, 1'b0, 1'b0);
    issue(1'b0);
    idle(1'b0);
    at_negedge();
    checkOutput("s6_level_pre", 32'(level_o), 32'd2);
    checkOutput("s6_outstanding_pre", 32'(outstanding_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1; clear_i = 1'b1; clear_addr_i = 32'h700; req_issued_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; clear_i = 1'b0; clear_addr_i = 32'h0; req_issued_i = 1'b0;
    at_negedge();
    checkOutput("s6_level", 32'(level_o), 32'd0);
    checkOutput("s6_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("s6_discard", 32'(discard_o), 32'd0);
    checkOutput("s6_valid", 32'(out_valid_o), 32'd0);
    checkOutput("s6_addr", out_addr_o, 32'h0);
    checkOutput("s6_allow", 32'(req_allow_o), 32'd1);

    idle(1'b1);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
